// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential CORDIC sine/cosine block.
//   state_e    : controller states (idle, iterate, publish result)
//   DATA_W     : datapath width, signed Q2.30
//   FRAC_W     : fraction bits of the Q2.30 datapath
//   ROM_ADDR_W : arctangent table address width
//   ROM_FRAC_W : fraction bits of the unsigned Q0.31 table data
//   K_Q230     : CORDIC gain compensation 0.6072529350 in Q2.30
package cordic_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FRAC_W     = 30;
    localparam int unsigned ROM_ADDR_W = 5;
    localparam int unsigned ROM_FRAC_W = 31;

    // round(0.6072529350 * 2^30)
    localparam logic signed [DATA_W-1:0] K_Q230 = 32'sd652032874;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/cordic_seq_rom.sv
// Combinational arctangent table: data = round(atan(2^-addr) * 2^31).
//   addr : iteration index 0..31
//   data : unsigned Q0.31 angle
module cordic_seq_rom
    import cordic_pkg::*;
(
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]     data
);

    always_comb begin
        data = '0;
        unique case (addr)
            5'd0:    data = 32'h6487ED51;
            5'd1:    data = 32'h3B58CE0A;
            5'd2:    data = 32'h1F5B75FA;
            5'd3:    data = 32'h0FEADD4E;
            5'd4:    data = 32'h07FD56EE;
            5'd5:    data = 32'h03FFAAB8;
            5'd6:    data = 32'h01FFF556;
            5'd7:    data = 32'h00FFFEAB;
            5'd8:    data = 32'h007FFFD5;
            5'd9:    data = 32'h003FFFFB;
            5'd10:   data = 32'h001FFFFF;
            // From here atan(2^-i) equals 2^-i to within half an LSB.
            default: data = 32'h1 << (5'd31 - addr);
        endcase
    end

endmodule

// File: rtl/cordic_seq.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q2.30 angle.
// One shift-add stage is reused for N_ITER cycles.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   start    : begin a computation (only honoured when idle)
//   angle    : signed Q2.30 radians, -1.0..+1.0
//   busy     : high while iterating
//   done     : one-cycle pulse when cos_out/sin_out are updated
//   cos_out  : signed Q2.30 cosine, held until the next done
//   sin_out  : signed Q2.30 sine, held until the next done
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int unsigned N_ITER = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] angle,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] cos_out,
    output logic signed [DATA_W-1:0] sin_out
);

    localparam logic [ROM_ADDR_W-1:0] LAST_ITER = ROM_ADDR_W'(N_ITER - 1);

    state_e                  state_q;
    logic [ROM_ADDR_W-1:0]   i_q;
    logic signed [DATA_W-1:0] x_q, y_q, z_q;

    logic [ROM_ADDR_W-1:0]    rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic signed [DATA_W-1:0] x_sh, y_sh, z_step;
    logic signed [DATA_W-1:0] x_nxt, y_nxt, z_nxt;
    logic                     z_neg;

    cordic_seq_rom u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    // Shared shift-add stage.
    always_comb begin
        rom_addr = (state_q == StRun) ? i_q : '0;
        x_sh     = x_q >>> i_q;
        y_sh     = y_q >>> i_q;
        // Q0.31 -> Q2.30, zero-extended since the table is unsigned.
        z_step   = signed'(rom_data >> 1);
        z_neg    = z_q[DATA_W-1];
        if (z_neg) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + z_step;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - z_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= K_Q230;
                        y_q     <= '0;
                        z_q     <= angle;
                        i_q     <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    if (i_q == LAST_ITER) begin
                        i_q     <= '0;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                StDone: begin
                    cos_out <= x_q;
                    sin_out <= y_q;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
module tb_cordic_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] angle;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [31:0] sin_out;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ANG_ZERO = 32'h00000000;
    localparam logic [31:0] ANG_PI6  = 32'd562209931;   // 0.5235988 * 2^30
    localparam logic [31:0] ANG_NEG1 = 32'hC0000000;    // -1.0

    localparam int ONE_Q30  = 1073741824;
    localparam int COS_PI6  = 929887692;   // 0.8660254 * 2^30
    localparam int SIN_PI6  = 536870912;   // 0.5 * 2^30
    localparam int COS_NEG1 = 580145177;   // 0.5403023 * 2^30
    localparam int SIN_NEG1 = -903522606;  // -0.8414710 * 2^30
    localparam int TOL      = 131072;      // 2^-13 in Q2.30

    cordic_seq #(.N_ITER(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .angle   (angle),
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out),
        .sin_out (sin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input int exp);
        longint d;
        bit     ok;
        total++;
        d  = longint'($signed(obs)) - longint'(exp);
        ok = !$isunknown(obs) && (d <= TOL) && (d >= -TOL);
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, $signed(obs), exp, TOL);
        end
    endtask

    // Start a run at edge 0 and return the edge on which done is seen (-1 on timeout).
    // angle is scrambled right after sampling; restart_at re-pulses start with another angle.
    task automatic run_calc(input logic [31:0] a, input int restart_at, output int lat);
        angle = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        angle = ~a;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == restart_at) begin
                start = 1'b1;
                angle = ANG_NEG1;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  saw_done;

        reset_n = 1'b0;
        start   = 1'b0;
        angle   = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cos", cos_out, 32'd0);
        check("rst_sin", sin_out, 32'd0);

        // Reset wins over start.
        start = 1'b1;
        angle = ANG_PI6;
        tick();
        check("rst_prio_busy", 32'(busy), 32'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // angle = 0
        run_calc(ANG_ZERO, 0, lat);
        check("lat_zero", 32'(lat), 32'd17);
        check_near("cos_zero", cos_out, ONE_Q30);
        check_near("sin_zero", sin_out, 0);
        tick();
        check("done_pulse_width", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check_near("cos_held", cos_out, ONE_Q30);

        // angle = pi/6
        run_calc(ANG_PI6, 0, lat);
        check("lat_pi6", 32'(lat), 32'd17);
        check_near("cos_pi6", cos_out, COS_PI6);
        check_near("sin_pi6", sin_out, SIN_PI6);
        tick();

        // angle = -1.0
        run_calc(ANG_NEG1, 0, lat);
        check("lat_neg1", 32'(lat), 32'd17);
        check_near("cos_neg1", cos_out, COS_NEG1);
        check_near("sin_neg1", sin_out, SIN_NEG1);
        tick();

        // Second start in cycle 5 with another angle is ignored.
        run_calc(ANG_PI6, 5, lat);
        check("lat_restart", 32'(lat), 32'd17);
        check_near("cos_restart", cos_out, COS_PI6);
        check_near("sin_restart", sin_out, SIN_PI6);
        tick();

        // Reset in cycle 8 aborts the run.
        angle = ANG_NEG1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_run", 32'(busy), 32'd1);
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cos", cos_out, 32'd0);
        check("abort_sin", sin_out, 32'd0);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_calc(ANG_PI6, 0, lat);
        check("lat_after_abort", 32'(lat), 32'd17);
        check_near("cos_after_abort", cos_out, COS_PI6);
        check_near("sin_after_abort", sin_out, SIN_PI6);
        tick();

        // start held high: period N_ITER+2, busy low for two cycles between runs.
        angle = ANG_NEG1;
        start = 1'b1;
        for (int e = 0; e < 54; e++) begin
            int pos;
            tick();
            pos = e % 18;
            check($sformatf("cont_busy_e%0d", e), 32'(busy), (pos <= 15) ? 32'd1 : 32'd0);
            check($sformatf("cont_done_e%0d", e), 32'(done), (pos == 17) ? 32'd1 : 32'd0);
        end
        start = 1'b0;
        check_near("cont_cos", cos_out, COS_NEG1);
        check_near("cont_sin", sin_out, SIN_NEG1);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
